// File: rtl/rr_arbiter_3x8.sv
// Round-robin arbiter, eight requesters, one-hot + binary grant.
// Grants are held while requested, capped at MAX_HOLD cycles.
module rr_arbiter_3x8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(MAX_HOLD);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [2:0]    id_n;
  logic [2:0]    win;
  logic [2:0]    idx;
  logic          found;
  logic          stop;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    gnt_n;

  // First requester at or after ptr, wrapping mod 8.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Active grant ends on release, disable or hold cap.
  always_comb begin
    stop = !req[gnt_id] || !en || (cnt == HOLD);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    id_n    = gnt_id;
    gnt_n   = gnt;
    unique case (state)
      IDLE: begin
        if (en && found) begin
          state_n = GRANT;
          id_n    = win;
          gnt_n   = 8'b1 << win;
          cnt_n   = ONE;
        end
      end
      GRANT: begin
        if (stop) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = gnt_id + 3'd1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      gnt_id <= '0;
      gnt    <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      gnt_id <= id_n;
      gnt    <= gnt_n;
    end
  end

  assign busy = (state == GRANT);

endmodule
